// File: rtl/cc_branch_unit.sv
// cc_branch_unit: N/Z/P classifier, per-context condition-code file and
// branch-enable evaluator with a one-entry valid/ready result register and
// saturating evaluation/taken statistics counters.
module cc_branch_unit #(
    parameter  int WIDTH   = 16,
    parameter  int NUM_CTX = 4,
    parameter  int CNT_W   = 16,
    localparam int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [WIDTH-1:0]       bus_data,
    input  logic                   LD_CC,
    input  logic [CTX_W-1:0]       cc_ctx,
    input  logic                   eval_valid,
    output logic                   eval_ready,
    input  logic [CTX_W-1:0]       eval_ctx,
    input  logic [2:0]             eval_mask,
    output logic                   ben_valid,
    input  logic                   ben_ready,
    output logic                   BEN,
    output logic                   ben_uninit,
    output logic [3*NUM_CTX-1:0]   cc_out,
    output logic [CNT_W-1:0]       eval_count,
    output logic [CNT_W-1:0]       taken_count,
    input  logic                   clr_stats
);

    // Context indices are compared against NUM_CTX with one spare bit so that
    // every encodable index, including the all-ones one, is handled.
    localparam logic [CTX_W:0]   NUM_CTX_V = (CTX_W + 1)'(NUM_CTX);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Counter increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [2:0]       r_cc [NUM_CTX];
    logic             r_ben_valid;
    logic             r_ben;
    logic             r_ben_uninit;
    logic [CNT_W-1:0] r_eval_count;
    logic [CNT_W-1:0] r_taken_count;

    logic             w_n;
    logic             w_z;
    logic             w_p;
    logic [2:0]       w_nzp;
    logic             w_wr_inr;
    logic             w_eval_inr;
    logic             w_fwd;
    logic [2:0]       w_cc_rd;
    logic [2:0]       w_cc_eff;
    logic             w_ben;
    logic             w_uninit;
    logic             w_fire;

    // Classification of the bus value: exactly one of n/z/p is set.
    assign w_n   = bus_data[WIDTH-1];
    assign w_z   = (bus_data == '0);
    assign w_p   = !w_n && !w_z;
    assign w_nzp = {w_n, w_z, w_p};

    assign w_wr_inr   = ({1'b0, cc_ctx}   < NUM_CTX_V);
    assign w_eval_inr = ({1'b0, eval_ctx} < NUM_CTX_V);

    // Read the addressed context; an out-of-range index reads as never loaded.
    always_comb begin
        w_cc_rd = 3'b000;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (eval_ctx == CTX_W'(i)) begin
                w_cc_rd = r_cc[i];
            end
        end
    end

    // A write to the context being evaluated in the same cycle wins over the
    // stored value, so the evaluation sees the freshly classified code.
    assign w_fwd    = LD_CC && w_wr_inr && (cc_ctx == eval_ctx);
    assign w_cc_eff = w_fwd ? w_nzp : w_cc_rd;
    assign w_ben    = w_eval_inr && (|(eval_mask & w_cc_eff));
    assign w_uninit = !w_eval_inr || (w_cc_eff == 3'b000);

    assign eval_ready = !r_ben_valid || ben_ready;
    assign w_fire     = eval_valid && eval_ready;

    // Condition-code file; writes to out-of-range contexts are dropped.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                r_cc[i] <= 3'b000;
            end
        end else if (LD_CC && w_wr_inr) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (cc_ctx == CTX_W'(i)) begin
                    r_cc[i] <= w_nzp;
                end
            end
        end
    end

    // Flatten the CC file onto cc_out, context i at bits [3i+2:3i].
    always_comb begin
        cc_out = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            cc_out[3*i +: 3] = r_cc[i];
        end
    end

    // One-entry result register: loads on accept, holds while stalled.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ben_valid  <= 1'b0;
            r_ben        <= 1'b0;
            r_ben_uninit <= 1'b0;
        end else if (w_fire) begin
            r_ben_valid  <= 1'b1;
            r_ben        <= w_ben;
            r_ben_uninit <= w_uninit;
        end else if (ben_ready) begin
            r_ben_valid  <= 1'b0;
        end
    end

    // Saturating statistics; a clear discards any same-cycle event.
    always_ff @(posedge Clk) begin
        if (Reset || clr_stats) begin
            r_eval_count  <= '0;
            r_taken_count <= '0;
        end else if (w_fire) begin
            r_eval_count <= sat_inc(r_eval_count);
            if (w_ben) begin
                r_taken_count <= sat_inc(r_taken_count);
            end
        end
    end

    assign ben_valid   = r_ben_valid;
    assign BEN         = r_ben;
    assign ben_uninit  = r_ben_uninit;
    assign eval_count  = r_eval_count;
    assign taken_count = r_taken_count;

endmodule

// File: tb/tb_cc_branch_unit.sv
// Self-checking bench for cc_branch_unit built with NUM_CTX=3, CNT_W=2:
// directed table and hand-written corner sequences, then randomized traffic
// compared against a behavioural model.
module tb_cc_branch_unit;

    localparam int WIDTH   = 16;
    localparam int NUM_CTX = 3;
    localparam int CNT_W   = 2;
    localparam int CTX_W   = 2;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic [WIDTH-1:0]     bus_data;
    logic                 LD_CC;
    logic [CTX_W-1:0]     cc_ctx;
    logic                 eval_valid;
    logic                 eval_ready;
    logic [CTX_W-1:0]     eval_ctx;
    logic [2:0]           eval_mask;
    logic                 ben_valid;
    logic                 ben_ready;
    logic                 BEN;
    logic                 ben_uninit;
    logic [3*NUM_CTX-1:0] cc_out;
    logic [CNT_W-1:0]     eval_count;
    logic [CNT_W-1:0]     taken_count;
    logic                 clr_stats;

    cc_branch_unit #(.WIDTH(WIDTH), .NUM_CTX(NUM_CTX), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .bus_data(bus_data), .LD_CC(LD_CC),
        .cc_ctx(cc_ctx), .eval_valid(eval_valid), .eval_ready(eval_ready),
        .eval_ctx(eval_ctx), .eval_mask(eval_mask), .ben_valid(ben_valid),
        .ben_ready(ben_ready), .BEN(BEN), .ben_uninit(ben_uninit),
        .cc_out(cc_out), .eval_count(eval_count), .taken_count(taken_count),
        .clr_stats(clr_stats)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] bus;
        logic [2:0]  exp_cc;
    } cls_vec_t;

    cls_vec_t cls_tab[5];

    // Behavioural model state
    int m_cc[NUM_CTX];
    int m_valid, m_ben, m_uninit, m_ec, m_tc;

    function automatic int classify(input logic [15:0] v);
        if (v[15]) return 4;
        if (v == 16'd0) return 2;
        return 1;
    endfunction

    function automatic int model_cc_out();
        int s = 0;
        for (int i = 0; i < NUM_CTX; i++) s += m_cc[i] << (3 * i);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CTX; i++) m_cc[i] = 0;
        m_valid = 0; m_ben = 0; m_uninit = 0; m_ec = 0; m_tc = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        int rdy, fire, nzp, eff, b, u, cmax;
        cmax = (1 << CNT_W) - 1;
        if (Reset) begin
            model_reset();
            return;
        end
        rdy  = (!m_valid || ben_ready) ? 1 : 0;
        fire = (eval_valid && rdy) ? 1 : 0;
        nzp  = classify(bus_data);
        if (int'(eval_ctx) < NUM_CTX) begin
            eff = (LD_CC && cc_ctx == eval_ctx) ? nzp : m_cc[eval_ctx];
            b   = ((int'(eval_mask) & eff) != 0) ? 1 : 0;
            u   = (eff == 0) ? 1 : 0;
        end else begin
            b = 0;
            u = 1;
        end
        if (clr_stats) begin
            m_ec = 0; m_tc = 0;
        end else if (fire) begin
            if (m_ec < cmax) m_ec++;
            if (b && m_tc < cmax) m_tc++;
        end
        if (fire) begin
            m_valid = 1; m_ben = b; m_uninit = u;
        end else if (ben_ready) begin
            m_valid = 0;
        end
        if (LD_CC && int'(cc_ctx) < NUM_CTX) m_cc[cc_ctx] = nzp;
    endtask

    initial begin
        cls_tab[0] = '{16'h8000, 3'b100};
        cls_tab[1] = '{16'h0000, 3'b010};
        cls_tab[2] = '{16'h0001, 3'b001};
        cls_tab[3] = '{16'h7fff, 3'b001};
        cls_tab[4] = '{16'hffff, 3'b100};

        Reset = 1; bus_data = '0; LD_CC = 0; cc_ctx = '0; eval_valid = 0;
        eval_ctx = '0; eval_mask = '0; ben_ready = 1; clr_stats = 0;
        step(); step();
        Reset = 0;
        #1;

        // Reset state
        check("rst_cc_out", 32'(cc_out), 32'd0);
        check("rst_ben_valid", 32'(ben_valid), 32'd0);
        check("rst_BEN", 32'(BEN), 32'd0);
        check("rst_uninit", 32'(ben_uninit), 32'd0);
        check("rst_eval_count", 32'(eval_count), 32'd0);
        check("rst_taken_count", 32'(taken_count), 32'd0);
        check("rst_eval_ready", 32'(eval_ready), 32'd1);

        // Never-loaded and out-of-range contexts
        eval_valid = 1; eval_ctx = 2'd2; eval_mask = 3'b111;
        step();
        check("uninit_valid", 32'(ben_valid), 32'd1);
        check("uninit_BEN", 32'(BEN), 32'd0);
        check("uninit_flag", 32'(ben_uninit), 32'd1);
        eval_ctx = 2'd3;
        step();
        check("range_BEN", 32'(BEN), 32'd0);
        check("range_flag", 32'(ben_uninit), 32'd1);
        eval_valid = 0;
        step();
        check("drain_valid", 32'(ben_valid), 32'd0);

        // Classification table loaded into context 0
        LD_CC = 1; cc_ctx = 2'd0;
        for (int i = 0; i < 5; i++) begin
            bus_data = cls_tab[i].bus;
            step();
            check($sformatf("cls_%0h", cls_tab[i].bus), 32'(cc_out[2:0]), 32'(cls_tab[i].exp_cc));
        end
        // Out-of-range write is ignored
        cc_ctx = 2'd3; bus_data = 16'h0000;
        step();
        check("oor_write", 32'(cc_out), 32'h004);

        // Forwarding: a same-cycle write to the evaluated context wins
        cc_ctx = 2'd1; bus_data = 16'h0001;
        step();
        bus_data = 16'h0000; eval_valid = 1; eval_ctx = 2'd1; eval_mask = 3'b010;
        step();
        check("fwd_z_BEN", 32'(BEN), 32'd1);
        check("fwd_z_uninit", 32'(ben_uninit), 32'd0);
        check("fwd_cc1", 32'(cc_out[5:3]), 32'b010);
        bus_data = 16'h0001; eval_valid = 0;
        step();
        bus_data = 16'h0000; eval_valid = 1; eval_mask = 3'b001;
        step();
        check("fwd_p_BEN", 32'(BEN), 32'd0);
        LD_CC = 0; eval_valid = 0;
        step();

        // Backpressure: cc[1] = z now
        clr_stats = 1;
        step();
        clr_stats = 0; ben_ready = 0;
        eval_valid = 1; eval_ctx = 2'd1; eval_mask = 3'b010;
        #1;
        check("bp_ready_first", 32'(eval_ready), 32'd1);
        step();
        eval_mask = 3'b001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_stall_ready_%0d", k), 32'(eval_ready), 32'd0);
            check($sformatf("bp_stall_BEN_%0d", k), 32'(BEN), 32'd1);
            check($sformatf("bp_stall_valid_%0d", k), 32'(ben_valid), 32'd1);
            step();
        end
        ben_ready = 1;
        #1;
        check("bp_release_ready", 32'(eval_ready), 32'd1);
        step();
        eval_valid = 0;
        check("bp_second_valid", 32'(ben_valid), 32'd1);
        check("bp_second_BEN", 32'(BEN), 32'd0);
        check("bp_eval_count", 32'(eval_count), 32'd2);
        check("bp_taken_count", 32'(taken_count), 32'd1);
        step();
        check("bp_drained", 32'(ben_valid), 32'd0);

        // Saturating counters
        clr_stats = 1;
        step();
        clr_stats = 0; eval_valid = 1; eval_ctx = 2'd1; eval_mask = 3'b010;
        for (int k = 0; k < 5; k++) step();
        check("sat_eval_count", 32'(eval_count), 32'd3);
        check("sat_taken_count", 32'(taken_count), 32'd3);
        clr_stats = 1;
        step();
        check("clr_eval_count", 32'(eval_count), 32'd0);
        check("clr_taken_count", 32'(taken_count), 32'd0);
        clr_stats = 0; eval_valid = 0;
        step();

        // Reset during a stall
        ben_ready = 0; eval_valid = 1;
        step();
        check("mid_stall_valid", 32'(ben_valid), 32'd1);
        check("mid_stall_ready", 32'(eval_ready), 32'd0);
        Reset = 1; LD_CC = 1; cc_ctx = 2'd0; bus_data = 16'h0001; clr_stats = 0;
        step();
        Reset = 0; LD_CC = 0; eval_valid = 0;
        #1;
        check("mid_rst_valid", 32'(ben_valid), 32'd0);
        check("mid_rst_ready", 32'(eval_ready), 32'd1);
        check("mid_rst_cc_out", 32'(cc_out), 32'd0);
        check("mid_rst_count", 32'(eval_count), 32'd0);

        // Randomized traffic against the model
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            case ($urandom_range(0, 3))
                0:       bus_data = 16'h0000;
                1:       bus_data = 16'h8000 | 16'($urandom);
                default: bus_data = 16'($urandom);
            endcase
            LD_CC      = ($urandom_range(0, 1) == 1);
            cc_ctx     = 2'($urandom_range(0, 3));
            eval_valid = ($urandom_range(0, 3) != 0);
            eval_ctx   = 2'($urandom_range(0, 3));
            eval_mask  = 3'($urandom_range(0, 7));
            ben_ready  = ($urandom_range(0, 9) < 7);
            clr_stats  = ($urandom_range(0, 29) == 0);
            Reset      = ($urandom_range(0, 149) == 0);
            #1;
            check("rnd_eval_ready", 32'(eval_ready), 32'((!m_valid || ben_ready) ? 1 : 0));
            model_clock();
            step();
            check("rnd_ben_valid", 32'(ben_valid), 32'(m_valid));
            if (m_valid != 0) begin
                check("rnd_BEN", 32'(BEN), 32'(m_ben));
                check("rnd_uninit", 32'(ben_uninit), 32'(m_uninit));
            end
            check("rnd_cc_out", 32'(cc_out), 32'(model_cc_out()));
            check("rnd_eval_count", 32'(eval_count), 32'(m_ec));
            check("rnd_taken_count", 32'(taken_count), 32'(m_tc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
